avl_width_split_bridge: RTL

AVL_WIDTH_SPLIT_BRIDGE -- requirements
Module: avl_width_split_bridge

---
 rtl/avl_width_split_bridge_if.sv | 26 ++
 rtl/avl_width_split_bridge.sv | 106 ++++++++++
 2 files changed

// File: rtl/avl_width_split_bridge_if.sv
// Avalon-MM style bus bundle; one instance per side of the width-split bridge.
interface avl_width_split_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  chipselect;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [BE_WIDTH-1:0]   be;
   logic                  write_req;
   logic                  read_req;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  waitrequest;

   modport master (
      output chipselect, addr, wdata, be, write_req, read_req,
      input  rdata, waitrequest
   );

   modport slave (
      input  chipselect, addr, wdata, be, write_req, read_req,
      output rdata, waitrequest
   );
endinterface

// File: rtl/avl_width_split_bridge.sv
// Splits one wide slave access into RATIO narrow master beats; read beats are
// reassembled into a wide word and the slave is released for a single cycle.
module avl_width_split_bridge #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH_M = 32,
   parameter int RATIO        = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   avl_width_split_bridge_if.slave           avl_slave,
   avl_width_split_bridge_if.master          avl_master
);
   localparam int DATA_WIDTH_S = RATIO * DATA_WIDTH_M;
   localparam int BE_WIDTH_M   = DATA_WIDTH_M / 8;
   localparam int BE_WIDTH_S   = RATIO * BE_WIDTH_M;
   localparam int BYTES_S      = BE_WIDTH_S;
   localparam int BEAT_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(BYTES_S - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t                  state, state_nxt;
   logic [BEAT_W-1:0]       beat, beat_nxt;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [DATA_WIDTH_S-1:0] wdata_q, rdata_q;
   logic [BE_WIDTH_S-1:0]   be_q;
   logic                    capture, store, advance, last;
   logic                    wr_go, rd_go;
   int                      beat_idx;
   logic [DATA_WIDTH_M-1:0] cur_wdata;
   logic [BE_WIDTH_M-1:0]   cur_be;

   assign beat_idx  = int'(beat);
   assign cur_wdata = wdata_q[beat_idx*DATA_WIDTH_M +: DATA_WIDTH_M];
   assign cur_be    = be_q[beat_idx*BE_WIDTH_M +: BE_WIDTH_M];
   assign last      = (beat == BEAT_W'(RATIO - 1));

   // A write beat with no enabled bytes is never presented to the master.
   assign wr_go = (state == WRITE) && (cur_be != '0);
   assign rd_go = (state == READ);

   assign avl_master.chipselect = wr_go | rd_go;
   assign avl_master.write_req  = wr_go;
   assign avl_master.read_req   = rd_go;
   assign avl_master.addr       = (state == WRITE || state == READ)
                                  ? base_q + ADDR_WIDTH'(beat_idx * BE_WIDTH_M) : '0;
   assign avl_master.wdata      = (state == WRITE) ? cur_wdata : '0;
   assign avl_master.be         = (state == WRITE) ? cur_be :
                                  (state == READ)  ? '1 : '0;

   assign avl_slave.waitrequest = (state != DONE);
   assign avl_slave.rdata       = rdata_q;

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      capture   = 1'b0;
      store     = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (avl_slave.chipselect && (avl_slave.write_req || avl_slave.read_req)) begin
               capture   = 1'b1;
               beat_nxt  = '0;
               state_nxt = avl_slave.write_req ? WRITE : READ;
            end
         end
         WRITE: advance = (cur_be == '0) || !avl_master.waitrequest;
         READ: begin
            advance = !avl_master.waitrequest;
            store   = !avl_master.waitrequest;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (advance) begin
         if (last) begin
            state_nxt = DONE;
            beat_nxt  = '0;
         end else begin
            beat_nxt = beat + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         beat    <= '0;
         base_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
         if (capture) begin
            base_q  <= avl_slave.addr & BASE_MASK;
            wdata_q <= avl_slave.wdata;
            be_q    <= avl_slave.be;
         end
         if (store)
            rdata_q[beat_idx*DATA_WIDTH_M +: DATA_WIDTH_M] <= avl_master.rdata;
      end
   end
endmodule
